// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: synchronizes INT, pushes the return PC (plus flags when
// INT_SAVE_FLAGS_EN is defined), vectors to VECTOR_ADDR and tracks the running handler.
module interrupt_sequencer #(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] VECTOR_ADDR = 32'h0000_0100,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              int_req,
  input  logic              instr_done,
  input  logic              halted,
  input  logic              reti,
  input  logic              ien_wr,
  input  logic              ien_wdata,
`ifdef INT_SAVE_FLAGS_EN
  input  logic [3:0]        flags_in,
`endif
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] sp_in,
  output logic              stall,
  output logic              sp_wr,
  output logic [DATA_W-1:0] sp_wdata,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_wdata,
  output logic              irq_ack,
  output logic              in_service,
  output logic              ien
);

`ifdef INT_SAVE_FLAGS_EN
  typedef enum logic [2:0] {IDLE, PUSH_PC, PUSH_FLG, VECTOR, SERVICE} state_t;
`else
  typedef enum logic [2:0] {IDLE, PUSH_PC, VECTOR, SERVICE} state_t;
`endif

  state_t                 state, nextState;
  logic [SYNC_STAGES-1:0] syncFf;
  logic [SYNC_STAGES:0]   armSr;
  logic                   syncPrev, intEdge, pending, ienQ;
  logic                   stallQ, pushQ, vecQ, inServiceQ, nextIsPush;
  logic [DATA_W-1:0]      spDec, pushData;

  // Edges only count once both the synchronized sample and its predecessor were
  // taken after reset release, so a level held high across reset is not an edge.
  assign intEdge = armSr[SYNC_STAGES] & syncFf[SYNC_STAGES-1] & ~syncPrev;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (pending && ienQ && (instr_done || halted)) nextState = PUSH_PC;
`ifdef INT_SAVE_FLAGS_EN
      PUSH_PC:  nextState = PUSH_FLG;
      PUSH_FLG: nextState = VECTOR;
`else
      PUSH_PC:  nextState = VECTOR;
`endif
      VECTOR:   nextState = SERVICE;
      SERVICE:  if (reti) nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  always_comb begin
`ifdef INT_SAVE_FLAGS_EN
    nextIsPush = (nextState == PUSH_PC) || (nextState == PUSH_FLG);
`else
    nextIsPush = (nextState == PUSH_PC);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncFf     <= '0;
      syncPrev   <= 1'b0;
      armSr      <= '0;
      pending    <= 1'b0;
      ienQ       <= 1'b0;
      state      <= IDLE;
      stallQ     <= 1'b0;
      pushQ      <= 1'b0;
      vecQ       <= 1'b0;
      inServiceQ <= 1'b0;
    end else begin
      syncFf     <= {syncFf[SYNC_STAGES-2:0], int_req};
      syncPrev   <= syncFf[SYNC_STAGES-1];
      armSr      <= {armSr[SYNC_STAGES-1:0], 1'b1};
      // A new edge wins over the clear in VECTOR.
      pending    <= intEdge | (pending & (state != VECTOR));
      if (ien_wr) ienQ <= ien_wdata;
      state      <= nextState;
      stallQ     <= nextIsPush | (nextState == VECTOR);
      pushQ      <= nextIsPush;
      vecQ       <= (nextState == VECTOR);
      inServiceQ <= (nextState == SERVICE);
    end
  end

  // Stack data tracks sp_in live so the flags push sees the already-decremented SP.
  assign spDec = sp_in - DATA_W'(4);

  always_comb begin
`ifdef INT_SAVE_FLAGS_EN
    pushData = (state == PUSH_FLG) ? {{(DATA_W-4){1'b0}}, flags_in} : pc_in;
`else
    pushData = pc_in;
`endif
  end

  assign stall      = stallQ;
  assign sp_wr      = pushQ;
  assign sp_wdata   = pushQ ? spDec : '0;
  assign mem_wr     = pushQ;
  assign mem_addr   = pushQ ? spDec : '0;
  assign mem_wdata  = pushQ ? pushData : '0;
  assign pc_load    = vecQ;
  assign pc_wdata   = vecQ ? VECTOR_ADDR : '0;
  assign irq_ack    = vecQ;
  assign in_service = inServiceQ;
  assign ien        = ienQ;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenarios plus random traffic against a
// cycle-level reference model driven from sampled int_req history.
`timescale 1ns/1ps
module tb_interrupt_sequencer;
  localparam int DW   = 32;
  localparam int SYNC = 2;
`ifdef INT_SAVE_FLAGS_EN
  localparam int NSEQ = 3;
`else
  localparam int NSEQ = 2;
`endif
  localparam int OW = 7 + 4*DW;

  logic          clk = 1'b0;
  logic          rst_n, int_req, instr_done, halted, reti, ien_wr, ien_wdata;
  logic [3:0]    flags_tb;
  logic [DW-1:0] pc_in, sp_in;
  logic          stall, sp_wr, mem_wr, pc_load, irq_ack, in_service, ien;
  logic [DW-1:0] sp_wdata, mem_addr, mem_wdata, pc_wdata;
  logic [OW-1:0] actVec;

  always #5 clk = ~clk;

  interrupt_sequencer #(.DATA_W(DW), .VECTOR_ADDR(32'h0000_0100), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .instr_done(instr_done),
    .halted(halted), .reti(reti), .ien_wr(ien_wr), .ien_wdata(ien_wdata),
`ifdef INT_SAVE_FLAGS_EN
    .flags_in(flags_tb),
`endif
    .pc_in(pc_in), .sp_in(sp_in), .stall(stall), .sp_wr(sp_wr), .sp_wdata(sp_wdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc_load(pc_load),
    .pc_wdata(pc_wdata), .irq_ack(irq_ack), .in_service(in_service), .ien(ien)
  );

  assign actVec = {stall, sp_wr, sp_wdata, mem_wr, mem_addr, mem_wdata,
                   pc_load, pc_wdata, irq_ack, in_service, ien};

  // Reference model: phase = cycles since entry (0 idle, 1..NSEQ entry steps,
  // NSEQ+1 handler); hist holds every int_req sample taken since reset release.
  logic hist[$];
  int   phase;
  bit   mPend, mIen;
  int   checks = 0;
  int   errors = 0;

  task automatic resetModel();
    hist.delete();
    phase = 0;
    mPend = 0;
    mIen  = 0;
  endtask

  task automatic cycle();
    int  cur, j, oldPhase;
    bit  setNow;
    @(posedge clk);
    if (!rst_n) begin
      resetModel();
    end else begin
      hist.push_back(int_req);
      cur    = hist.size() - 1;
      j      = cur - SYNC;
      setNow = 0;
      if (j >= 1) setNow = hist[j] && !hist[j-1];
      oldPhase = phase;
      if (phase == 0) begin
        if (mPend && mIen && (instr_done || halted)) phase = 1;
      end else if (phase <= NSEQ) begin
        phase++;
      end else if (reti) begin
        phase = 0;
      end
      mPend = setNow || (mPend && oldPhase != NSEQ);
      if (ien_wr) mIen = ien_wdata;
    end
    #1;
  endtask

  function automatic logic [OW-1:0] expVec();
    logic          st, pw, pl, ia, isv;
    logic [DW-1:0] addr, wd, pcw;
    st = 0; pw = 0; pl = 0; ia = 0; isv = 0;
    addr = '0; wd = '0; pcw = '0;
    if (phase == 1 || (NSEQ == 3 && phase == 2)) begin
      st = 1; pw = 1; addr = sp_in - 32'd4;
      wd = (phase == 1) ? pc_in : {28'd0, flags_tb};
    end else if (phase == NSEQ) begin
      st = 1; pl = 1; ia = 1; pcw = 32'h0000_0100;
    end else if (phase == NSEQ + 1) begin
      isv = 1;
    end
    return {st, pw, addr, pw, addr, wd, pl, pcw, ia, isv, mIen};
  endfunction

  task automatic test_reset();
    rst_n = 0; int_req = 1; instr_done = 0; halted = 0; reti = 0;
    ien_wr = 0; ien_wdata = 0; flags_tb = 4'h0; pc_in = '0; sp_in = '0;
    #3;
    checks++;
    if (actVec !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", actVec); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    resetModel();
    ien_wr = 1; ien_wdata = 1; halted = 1;
    cycle();
    ien_wr = 0;
    checks++;
    if (ien !== 1'b1) begin errors++; $display("FAIL ien_write: got %b want 1", ien); end
    // int_req was high across release: must never count as an edge
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if (stall !== 1'b0 || actVec !== expVec()) begin
        errors++; $display("FAIL reset_level_no_edge: got %h want %h", actVec, expVec());
      end
    end
    int_req = 0; halted = 0;
    repeat (SYNC + 2) cycle();
  endtask

  task automatic test_basic();
    sp_in = 32'h200; pc_in = 32'h40; flags_tb = 4'hA;
    int_req = 1;
    for (int i = 0; i < SYNC + 2; i++) begin
      cycle();
      checks++;
      if (actVec !== expVec()) begin errors++; $display("FAIL basic_wait: got %h want %h", actVec, expVec()); end
    end
    instr_done = 1;
    cycle();
    instr_done = 0;
    checks++;
    if ({stall, mem_wr, mem_addr, mem_wdata, sp_wr, sp_wdata} !== {1'b1, 1'b1, 32'h1FC, 32'h40, 1'b1, 32'h1FC}) begin
      errors++; $display("FAIL basic_push_pc: got addr %h data %h sp %h want 1fc 40 1fc", mem_addr, mem_wdata, sp_wdata);
    end
`ifdef INT_SAVE_FLAGS_EN
    cycle();
    sp_in = 32'h1FC;
    #1;
    checks++;
    if ({stall, mem_wr, mem_addr, mem_wdata, sp_wr, sp_wdata} !== {1'b1, 1'b1, 32'h1F8, 32'hA, 1'b1, 32'h1F8}) begin
      errors++; $display("FAIL basic_push_flags: got addr %h data %h sp %h want 1f8 a 1f8", mem_addr, mem_wdata, sp_wdata);
    end
`endif
    cycle();
    checks++;
    if ({stall, mem_wr, pc_load, pc_wdata, irq_ack} !== {1'b1, 1'b0, 1'b1, 32'h100, 1'b1}) begin
      errors++; $display("FAIL basic_vector: got pc_load %b pc %h ack %b want 1 100 1", pc_load, pc_wdata, irq_ack);
    end
    cycle();
    checks++;
    if ({stall, in_service, irq_ack} !== 3'b010 || actVec !== expVec()) begin
      errors++; $display("FAIL basic_service: got %h want %h", actVec, expVec());
    end
    int_req = 0; reti = 1;
    cycle();
    reti = 0;
    checks++;
    if (in_service !== 1'b0 || actVec !== expVec()) begin
      errors++; $display("FAIL basic_reti: got %h want %h", actVec, expVec());
    end
  endtask

  task automatic test_masked();
    ien_wr = 1; ien_wdata = 0;
    cycle();
    ien_wr = 0;
    int_req = 1;
    repeat (SYNC + 2) cycle();
    for (int p = 0; p < 5; p++) begin
      instr_done = 1;
      cycle();
      instr_done = 0;
      checks++;
      if (stall !== 1'b0 || mem_wr !== 1'b0 || actVec !== expVec()) begin
        errors++; $display("FAIL masked_no_entry: got %h want %h", actVec, expVec());
      end
      cycle();
    end
    ien_wr = 1; ien_wdata = 1;
    cycle();
    ien_wr = 0; instr_done = 1;
    cycle();
    instr_done = 0;
    checks++;
    if (mem_wr !== 1'b1 || mem_addr !== sp_in - 32'd4 || actVec !== expVec()) begin
      errors++; $display("FAIL masked_then_enabled: got %h want %h", actVec, expVec());
    end
    int_req = 0;
    repeat (NSEQ) cycle();
    reti = 1;
    cycle();
    reti = 0;
    repeat (SYNC + 2) cycle();
  endtask

  task automatic test_halt_wake();
    int first;
    first = -1;
    halted = 1;
    int_req = 1;
    // c counts clock edges after the one that first samples int_req high
    for (int c = 0; c <= SYNC + 4; c++) begin
      cycle();
      if (mem_wr === 1'b1 && first < 0) first = c;
    end
    checks++;
    if (first != SYNC + 1) begin errors++; $display("FAIL halt_wake_latency: got %0d want %0d", first, SYNC + 1); end
    halted = 0;
    checks++;
    if (actVec !== expVec()) begin errors++; $display("FAIL halt_wake_state: got %h want %h", actVec, expVec()); end
    int_req = 0;
    reti = 1;
    cycle();
    reti = 0;
    repeat (SYNC + 2) cycle();
  endtask

  task automatic test_edge_in_service();
    int_req = 1;
    repeat (SYNC + 2) cycle();
    instr_done = 1;
    cycle();
    instr_done = 0;
    repeat (NSEQ) cycle();
    int_req = 0;
    cycle();
    int_req = 1;
    for (int i = 0; i < SYNC + 4; i++) begin
      cycle();
      checks++;
      if (in_service !== 1'b1 || actVec !== expVec()) begin
        errors++; $display("FAIL service_hold: got %h want %h", actVec, expVec());
      end
    end
    reti = 1;
    cycle();
    reti = 0;
    checks++;
    if (in_service !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL service_reti: got in_service %b stall %b want 0 0", in_service, stall);
    end
    instr_done = 1;
    cycle();
    instr_done = 0;
    checks++;
    if (mem_wr !== 1'b1 || actVec !== expVec()) begin
      errors++; $display("FAIL second_entry: got %h want %h", actVec, expVec());
    end
    int_req = 0;
    repeat (NSEQ) cycle();
    reti = 1;
    cycle();
    reti = 0;
    repeat (SYNC + 2) cycle();
  endtask

  task automatic test_reset_in_vector();
    int_req = 1;
    repeat (SYNC + 2) cycle();
    instr_done = 1;
    cycle();
    instr_done = 0;
    repeat (NSEQ - 1) cycle();
    checks++;
    if (pc_load !== 1'b1 || irq_ack !== 1'b1) begin
      errors++; $display("FAIL pre_reset_vector: got pc_load %b ack %b want 1 1", pc_load, irq_ack);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (actVec !== '0) begin errors++; $display("FAIL async_reset_vector: got %h want 0", actVec); end
    resetModel();
    @(posedge clk);
    #1;
    rst_n = 1;
    ien_wr = 1; ien_wdata = 1;
    cycle();
    ien_wr = 0; instr_done = 1;
    for (int i = 0; i < SYNC + 4; i++) begin
      cycle();
      checks++;
      if (stall !== 1'b0 || actVec !== expVec()) begin
        errors++; $display("FAIL post_reset_idle: got %h want %h", actVec, expVec());
      end
    end
    instr_done = 0; int_req = 0;
    repeat (SYNC + 2) cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      instr_done = ($urandom_range(0, 99) < 30);
      halted     = ($urandom_range(0, 99) < 10);
      reti       = ($urandom_range(0, 99) < 15);
      ien_wr     = ($urandom_range(0, 99) < 5);
      ien_wdata  = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 99) < 8) int_req = ~int_req;
      sp_in    = $urandom;
      pc_in    = $urandom;
      flags_tb = 4'($urandom);
      cycle();
      checks++;
      if (actVec !== expVec()) begin
        errors++; $display("FAIL random_cycle %0d: got %h want %h", i, actVec, expVec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_masked();
    test_halt_wake();
    test_edge_in_service();
    test_reset_in_vector();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, datapath word width; VECTOR_ADDR, 32'h0000_0100, handler entry address; SYNC_STAGES, 2, INT synchronizer depth (minimum 2).
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- int_req  in  1  asynchronous external interrupt pin (INT).
- instr_done  in  1  one-cycle pulse from the control unit at an instruction boundary.
- halted  in  1  control unit is in HALT (haltPC asserted).
- reti  in  1  one-cycle pulse when a return-from-interrupt retires.
- ien_wr  in  1  write strobe for the interrupt-enable bit.
- ien_wdata  in  1  new interrupt-enable value.
- pc_in  in  DATA_W  address of the next instruction to execute.
- sp_in  in  DATA_W  current stack pointer.
- stall  out  1  freeze the control unit and PC update.
- sp_wr  out  1  stack pointer write strobe.
- sp_wdata  out  DATA_W  new stack pointer.
- mem_wr  out  1  data memory write strobe.
- mem_addr  out  DATA_W  data memory address.
- mem_wdata  out  DATA_W  data memory write data.
- pc_load  out  1  force the PC.
- pc_wdata  out  DATA_W  forced PC value.
- irq_ack  out  1  one-cycle acknowledge pulse.
- in_service  out  1  handler running.
- ien  out  1  current interrupt-enable bit.

Function
REQ-003 int_req SHALL pass through a SYNC_STAGES flop synchronizer; a rising edge of the synchronized signal SHALL set the pending flag on the next clk.
REQ-004 FSM states SHALL be IDLE, PUSH_PC, VECTOR, SERVICE (plus PUSH_FLG under REQ-016).
REQ-005 IDLE -> PUSH_PC SHALL occur when pending, ien and (instr_done or halted) are all 1 in the same cycle; otherwise the FSM SHALL stay in IDLE.
REQ-006 PUSH_PC SHALL last one cycle with: stall=1, mem_wr=1, mem_addr=sp_in-4, mem_wdata=pc_in, sp_wr=1, sp_wdata=sp_in-4 (modulo 2^DATA_W).
REQ-007 VECTOR SHALL last one cycle with: stall=1, pc_load=1, pc_wdata=VECTOR_ADDR, irq_ack=1; pending SHALL clear at the end of this cycle.
REQ-008 SERVICE SHALL hold in_service=1; reti SHALL return the FSM to IDLE on the next clk.
REQ-009 Latency SHALL be: qualifying instr_done in cycle N -> PUSH_PC in N+1, VECTOR in N+2, SERVICE in N+3.
REQ-010 reti outside SERVICE SHALL be ignored; no nesting is allowed.
- An edge arriving during PUSH_PC, VECTOR or SERVICE SHALL set or keep pending.
- A pending interrupt SHALL be taken at the first qualifying boundary after returning to IDLE.
- If a new edge coincides with the VECTOR clear, the set SHALL win and pending SHALL stay 1.
REQ-011 ien_wr SHALL update ien on the next clk in any state.
- Clearing ien SHALL NOT abort a sequence already in PUSH_PC or VECTOR.
- A pending interrupt with ien=0 SHALL be retained, not dropped.
REQ-012 Whenever a strobe (mem_wr, sp_wr, pc_load) is 0, the corresponding data outputs SHALL be 0.
- Outside the states named in REQ-006 to REQ-008, all outputs except ien SHALL be 0.

Reset
REQ-013 rst_n=0 SHALL immediately, without waiting for clk, force: FSM=IDLE, pending=0, synchronizer flops=0, ien=0, all outputs=0.
REQ-014 Reset asserted mid-sequence (PUSH_PC, VECTOR or SERVICE) SHALL abandon the sequence with no further strobes.
REQ-015 An int_req level already high when reset releases SHALL NOT register as an edge.

Configuration
REQ-016 With macro INT_SAVE_FLAGS_EN defined:
- An input flags_in [3:0] SHALL be added.
- A state PUSH_FLG SHALL be inserted between PUSH_PC and VECTOR, with: stall=1, mem_wr=1, mem_addr=sp_in-4, mem_wdata zero-extended flags_in, sp_wr=1, sp_wdata=sp_in-4.
- Entry latency to SERVICE SHALL become 4 cycles.
REQ-017 Without INT_SAVE_FLAGS_EN, flags_in and PUSH_FLG SHALL NOT exist.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Basic entry: ien=1, sp_in=0x200, pc_in=0x40, int_req rises, instr_done after sync -> mem write 0x40 @0x1FC, sp_wdata=0x1FC, then pc_wdata=0x100 with irq_ack, in_service=1.
- Masked interrupt: ien=0, edge, 5 instr_done pulses -> no strobes; set ien=1, next instr_done -> entry sequence starts.
- Wake from halt: halted=1, ien=1, edge -> PUSH_PC exactly SYNC_STAGES+1 cycles after the edge, without any instr_done.
- Edge in service: second edge during SERVICE, then reti -> IDLE, and the next instr_done starts a second entry.
- Async reset in VECTOR: rst_n low mid-cycle -> pc_load and irq_ack drop immediately; after release the FSM is IDLE with pending=0.
- INT_SAVE_FLAGS_EN: flags_in=4'hA, sp_in=0x200 -> writes 0x40 @0x1FC, then 0xA @0x1F8 after sp_in is updated to 0x1FC, then vector.
